// File: rtl/trigger_pkg.sv
// Shared types and constants for the oscilloscope trigger unit.
//   - state_e  : trigger state machine encoding
//   - EdgeRise / EdgeFall : values of the edge_fall select input
//   - DefDataW / DefCntW  : default sample and counter widths
package trigger_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefCntW  = 16;

  localparam logic EdgeRise = 1'b0;
  localparam logic EdgeFall = 1'b1;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_HOLDOFF,
    ST_ARMING,
    ST_ARMED,
    ST_FIRED
  } state_e;

endpackage

// File: rtl/trig_threshold.sv
// Threshold compare for the trigger unit. Derives the hysteresis-adjusted arm
// threshold (lo = level-hyst saturated at 0, hi = level+hyst saturated at
// all-ones) and flags whether the current sample arms or fires for the
// selected edge.
// Ports:
//   adc_data_i  - current sample
//   level_i     - trigger threshold
//   hyst_i      - hysteresis band
//   edge_fall_i - 0 = rising edge, 1 = falling edge
//   arm_hit_o   - sample is on the arming side of the hysteresis band
//   fire_hit_o  - sample has crossed the trigger level
module trig_threshold
  import trigger_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic [DATA_W-1:0] level_i,
  input  logic [DATA_W-1:0] hyst_i,
  input  logic              edge_fall_i,
  output logic              arm_hit_o,
  output logic              fire_hit_o
);

  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] hi;
  logic [DATA_W:0]   sum;

  assign lo  = (level_i >= hyst_i) ? (level_i - hyst_i) : '0;
  // One extra bit catches the carry so hi can saturate instead of wrapping.
  assign sum = {1'b0, level_i} + {1'b0, hyst_i};
  assign hi  = sum[DATA_W] ? '1 : sum[DATA_W-1:0];

  always_comb begin
    arm_hit_o  = 1'b0;
    fire_hit_o = 1'b0;
    if (edge_fall_i == EdgeFall) begin
      arm_hit_o  = (adc_data_i >= hi);
      fire_hit_o = (adc_data_i <= level_i);
    end else begin
      arm_hit_o  = (adc_data_i <= lo);
      fire_hit_o = (adc_data_i >= level_i);
    end
  end

endmodule

// File: rtl/trigger_unit.sv
// Edge trigger with hysteresis, holdoff and optional auto-trigger.
// Optional feature macro: TRIGGER_AUTO_EN (builds the auto-timeout counter).
// Ports:
//   clk_50mhz    - clock, all state on rising edge
//   reset        - asynchronous active-low reset
//   adc_data     - current ADC sample, qualified by sample_valid
//   sample_valid - one-cycle strobe for a new sample
//   trig_reset   - level; while high the unit is disarmed and cleared
//   level, hyst, edge_fall - threshold, hysteresis band, edge select
//   holdoff      - valid samples ignored after trig_reset falls
//   auto_timeout - valid samples before a forced trigger (0 = off)
//   trig         - sticky trigger flag
//   armed        - high while armed
//   auto_fired   - trig came from the auto timeout
module trigger_unit
  import trigger_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              sample_valid,
  input  logic              trig_reset,
  input  logic [DATA_W-1:0] level,
  input  logic [DATA_W-1:0] hyst,
  input  logic              edge_fall,
  input  logic [CNT_W-1:0]  holdoff,
  input  logic [CNT_W-1:0]  auto_timeout,
  output logic              trig,
  output logic              armed,
  output logic              auto_fired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             arm_hit, fire_hit;
  logic             auto_hit;
  logic             auto_fire;

  trig_threshold #(
    .DATA_W (DATA_W)
  ) u_threshold (
    .adc_data_i  (adc_data),
    .level_i     (level),
    .hyst_i      (hyst),
    .edge_fall_i (edge_fall),
    .arm_hit_o   (arm_hit),
    .fire_hit_o  (fire_hit)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    auto_fire  = 1'b0;
    if (trig_reset) begin
      state_d    = ST_CLEAR;
      hold_cnt_d = holdoff;
    end else begin
      unique case (state_q)
        // Reloading here makes a release from reset behave like a trig_reset fall.
        ST_CLEAR: begin
          state_d    = ST_HOLDOFF;
          hold_cnt_d = holdoff;
        end
        ST_HOLDOFF: begin
          if (sample_valid) begin
            if (hold_cnt_q <= CNT_W'(1)) begin
              state_d    = ST_ARMING;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q - CNT_W'(1);
            end
          end
        end
        ST_ARMING: begin
          if (sample_valid) begin
            if (auto_hit) begin
              state_d   = ST_FIRED;
              auto_fire = 1'b1;
            end else if (arm_hit) begin
              state_d = ST_ARMED;
            end
          end
        end
        ST_ARMED: begin
          // A real edge outranks the timeout on the same sample.
          if (sample_valid) begin
            if (fire_hit) begin
              state_d = ST_FIRED;
            end else if (auto_hit) begin
              state_d   = ST_FIRED;
              auto_fire = 1'b1;
            end
          end
        end
        ST_FIRED: state_d = ST_FIRED;
        default:  state_d = ST_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign trig  = (state_q == ST_FIRED);
  assign armed = (state_q == ST_ARMED);

`ifdef TRIGGER_AUTO_EN
  logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d, auto_cnt_inc;
  logic             auto_fired_q, auto_fired_d;

  assign auto_cnt_inc = (&auto_cnt_q) ? auto_cnt_q : (auto_cnt_q + CNT_W'(1));
  assign auto_hit     = (auto_timeout != '0) && (auto_cnt_inc >= auto_timeout);

  always_comb begin
    auto_cnt_d   = auto_cnt_q;
    auto_fired_d = auto_fired_q;
    if (trig_reset) begin
      auto_cnt_d   = '0;
      auto_fired_d = 1'b0;
    end else if (state_q == ST_CLEAR || state_q == ST_HOLDOFF) begin
      // Held at zero until ST_ARMING is entered.
      auto_cnt_d = '0;
    end else if (sample_valid && (state_q == ST_ARMING || state_q == ST_ARMED)) begin
      auto_cnt_d = auto_cnt_inc;
      if (auto_fire) begin
        auto_fired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      auto_cnt_q   <= '0;
      auto_fired_q <= 1'b0;
    end else begin
      auto_cnt_q   <= auto_cnt_d;
      auto_fired_q <= auto_fired_d;
    end
  end

  assign auto_fired = auto_fired_q;
`else
  logic unused_auto;
  assign auto_hit    = 1'b0;
  assign auto_fired  = 1'b0;
  assign unused_auto = ^{auto_timeout, auto_fire};
`endif

endmodule

// File: tb/tb_trigger_unit.sv
module tb_trigger_unit;

  logic        clk_50mhz;
  logic        reset;
  logic [7:0]  adc_data;
  logic        sample_valid;
  logic        trig_reset;
  logic [7:0]  level;
  logic [7:0]  hyst;
  logic        edge_fall;
  logic [15:0] holdoff;
  logic [15:0] auto_timeout;
  logic        trig;
  logic        armed;
  logic        auto_fired;

  int checks;
  int failures;

  trigger_unit #(
    .DATA_W (8),
    .CNT_W  (16)
  ) dut (
    .clk_50mhz    (clk_50mhz),
    .reset        (reset),
    .adc_data     (adc_data),
    .sample_valid (sample_valid),
    .trig_reset   (trig_reset),
    .level        (level),
    .hyst         (hyst),
    .edge_fall    (edge_fall),
    .holdoff      (holdoff),
    .auto_timeout (auto_timeout),
    .trig         (trig),
    .armed        (armed),
    .auto_fired   (auto_fired)
  );

  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One valid strobe; outputs are settled when this returns.
  task automatic sample(input logic [7:0] v);
    @(negedge clk_50mhz);
    adc_data     = v;
    sample_valid = 1'b1;
    @(negedge clk_50mhz);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_trig_reset();
    @(negedge clk_50mhz);
    trig_reset = 1'b1;
    @(negedge clk_50mhz);
    trig_reset = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] lv, input logic [7:0] hy, input logic ef,
                     input logic [15:0] ho, input logic [15:0] at);
    level        = lv;
    hyst         = hy;
    edge_fall    = ef;
    holdoff      = ho;
    auto_timeout = at;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (trig !== 1'b0) begin
      failures++;
      $display("FAIL reset_trig: got %b want 0", trig);
    end
    checks++;
    if (armed !== 1'b0) begin
      failures++;
      $display("FAIL reset_armed: got %b want 0", armed);
    end
    checks++;
    if (auto_fired !== 1'b0) begin
      failures++;
      $display("FAIL reset_auto_fired: got %b want 0", auto_fired);
    end
    repeat (2) @(negedge clk_50mhz);
    reset = 1'b1;
  endtask

  task automatic test_rising();
    cfg(8'd128, 8'd8, 1'b0, 16'd0, 16'd0);
    pulse_trig_reset();
    sample(8'd100);
    checks++;
    if (armed !== 1'b0) begin
      failures++;
      $display("FAIL rise_holdoff_sample: armed got %b want 0", armed);
    end
    sample(8'd119);
    checks++;
    if (armed !== 1'b1 || trig !== 1'b0) begin
      failures++;
      $display("FAIL rise_arm: armed/trig got %b/%b want 1/0", armed, trig);
    end
    sample(8'd125);
    checks++;
    if (trig !== 1'b0) begin
      failures++;
      $display("FAIL rise_below_level: trig got %b want 0", trig);
    end
    @(negedge clk_50mhz);
    adc_data     = 8'd130;
    sample_valid = 1'b1;
    #5;
    checks++;
    if (trig !== 1'b0) begin
      failures++;
      $display("FAIL rise_latency: trig got %b before edge want 0", trig);
    end
    @(negedge clk_50mhz);
    sample_valid = 1'b0;
    checks++;
    if (trig !== 1'b1 || armed !== 1'b0 || auto_fired !== 1'b0) begin
      failures++;
      $display("FAIL rise_fire: trig/armed/auto got %b/%b/%b want 1/0/0", trig, armed,
               auto_fired);
    end
    sample(8'd50);
    sample(8'd0);
    checks++;
    if (trig !== 1'b1) begin
      failures++;
      $display("FAIL rise_sticky: trig got %b want 1", trig);
    end
  endtask

  task automatic test_hyst_reject();
    logic [7:0] seq [4];
    seq = '{8'd125, 8'd130, 8'd125, 8'd130};
    cfg(8'd128, 8'd8, 1'b0, 16'd0, 16'd0);
    pulse_trig_reset();
    sample(8'd200);
    for (int i = 0; i < 4; i++) begin
      sample(seq[i]);
      checks++;
      if (trig !== 1'b0 || armed !== 1'b0) begin
        failures++;
        $display("FAIL hyst_reject[%0d]: trig/armed got %b/%b want 0/0", i, trig, armed);
      end
    end
  endtask

  task automatic test_fall_sat();
    cfg(8'd250, 8'd20, 1'b1, 16'd0, 16'd0);
    pulse_trig_reset();
    sample(8'd0);
    sample(8'd254);
    checks++;
    if (armed !== 1'b0) begin
      failures++;
      $display("FAIL fall_below_hi: armed got %b want 0", armed);
    end
    sample(8'd255);
    checks++;
    if (armed !== 1'b1 || trig !== 1'b0) begin
      failures++;
      $display("FAIL fall_arm_sat: armed/trig got %b/%b want 1/0", armed, trig);
    end
    sample(8'd249);
    checks++;
    if (trig !== 1'b1) begin
      failures++;
      $display("FAIL fall_fire: trig got %b want 1", trig);
    end
  endtask

  task automatic test_arm_no_fire();
    cfg(8'd100, 8'd0, 1'b0, 16'd0, 16'd0);
    pulse_trig_reset();
    sample(8'd200);
    sample(8'd100);
    checks++;
    if (armed !== 1'b1 || trig !== 1'b0) begin
      failures++;
      $display("FAIL arm_no_fire: armed/trig got %b/%b want 1/0", armed, trig);
    end
    sample(8'd100);
    checks++;
    if (trig !== 1'b1) begin
      failures++;
      $display("FAIL arm_then_fire: trig got %b want 1", trig);
    end
  endtask

  task automatic test_holdoff();
    logic [7:0] seq [3];
    seq = '{8'd100, 8'd130, 8'd100};
    cfg(8'd128, 8'd8, 1'b0, 16'd3, 16'd0);
    pulse_trig_reset();
    // Idle cycles must not consume holdoff.
    repeat (6) @(negedge clk_50mhz);
    for (int i = 0; i < 3; i++) begin
      sample(seq[i]);
      checks++;
      if (armed !== 1'b0 || trig !== 1'b0) begin
        failures++;
        $display("FAIL holdoff_ignore[%0d]: armed/trig got %b/%b want 0/0", i, armed, trig);
      end
    end
    sample(8'd100);
    checks++;
    if (armed !== 1'b1) begin
      failures++;
      $display("FAIL holdoff_arm4: armed got %b want 1", armed);
    end
    sample(8'd130);
    checks++;
    if (trig !== 1'b1) begin
      failures++;
      $display("FAIL holdoff_fire: trig got %b want 1", trig);
    end
  endtask

  task automatic test_priority();
    cfg(8'd128, 8'd8, 1'b0, 16'd0, 16'd0);
    pulse_trig_reset();
    sample(8'd0);
    sample(8'd100);
    @(negedge clk_50mhz);
    adc_data     = 8'd130;
    sample_valid = 1'b1;
    trig_reset   = 1'b1;
    @(negedge clk_50mhz);
    sample_valid = 1'b0;
    trig_reset   = 1'b0;
    checks++;
    if (trig !== 1'b0 || armed !== 1'b0) begin
      failures++;
      $display("FAIL prio_trig_reset: trig/armed got %b/%b want 0/0", trig, armed);
    end
  endtask

  task automatic test_async_reset();
    cfg(8'd128, 8'd8, 1'b0, 16'd2, 16'd0);
    pulse_trig_reset();
    sample(8'd0);
    sample(8'd0);
    sample(8'd100);
    checks++;
    if (armed !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup: armed got %b want 1", armed);
    end
    @(negedge clk_50mhz);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (armed !== 1'b0 || trig !== 1'b0 || auto_fired !== 1'b0) begin
      failures++;
      $display("FAIL areset_armed: armed/trig/auto got %b/%b/%b want 0/0/0", armed, trig,
               auto_fired);
    end
    #3 reset = 1'b1;
    // Holdoff of 2 must apply again after release.
    sample(8'd100);
    sample(8'd100);
    checks++;
    if (armed !== 1'b0) begin
      failures++;
      $display("FAIL areset_holdoff: armed got %b want 0", armed);
    end
    sample(8'd100);
    sample(8'd130);
    checks++;
    if (trig !== 1'b1) begin
      failures++;
      $display("FAIL areset_refire: trig got %b want 1", trig);
    end
    @(negedge clk_50mhz);
    #3 reset = 1'b0;
    #1;
    checks++;
    if (trig !== 1'b0) begin
      failures++;
      $display("FAIL areset_fired: trig got %b want 0", trig);
    end
    @(negedge clk_50mhz);
    reset = 1'b1;
  endtask

`ifdef TRIGGER_AUTO_EN
  task automatic test_auto();
    cfg(8'd32, 8'd8, 1'b0, 16'd0, 16'd5);
    pulse_trig_reset();
    sample(8'd64);
    for (int i = 1; i <= 4; i++) begin
      sample(8'd64);
      checks++;
      if (trig !== 1'b0) begin
        failures++;
        $display("FAIL auto_early[%0d]: trig got %b want 0", i, trig);
      end
    end
    sample(8'd64);
    checks++;
    if (trig !== 1'b1 || auto_fired !== 1'b1) begin
      failures++;
      $display("FAIL auto_fire: trig/auto got %b/%b want 1/1", trig, auto_fired);
    end
    pulse_trig_reset();
    checks++;
    if (auto_fired !== 1'b0 || trig !== 1'b0) begin
      failures++;
      $display("FAIL auto_clear: trig/auto got %b/%b want 0/0", trig, auto_fired);
    end
    // Real edge coincides with timeout on the third counted sample.
    cfg(8'd32, 8'd8, 1'b0, 16'd0, 16'd3);
    sample(8'd64);
    sample(8'd10);
    sample(8'd10);
    sample(8'd40);
    checks++;
    if (trig !== 1'b1 || auto_fired !== 1'b0) begin
      failures++;
      $display("FAIL auto_edge_prio: trig/auto got %b/%b want 1/0", trig, auto_fired);
    end
    cfg(8'd32, 8'd8, 1'b0, 16'd0, 16'd0);
    pulse_trig_reset();
    repeat (8) sample(8'd64);
    checks++;
    if (trig !== 1'b0) begin
      failures++;
      $display("FAIL auto_disabled: trig got %b want 0", trig);
    end
  endtask
`else
  task automatic test_auto();
    cfg(8'd32, 8'd8, 1'b0, 16'd0, 16'd5);
    pulse_trig_reset();
    repeat (8) sample(8'd64);
    checks++;
    if (trig !== 1'b0 || auto_fired !== 1'b0) begin
      failures++;
      $display("FAIL auto_absent: trig/auto got %b/%b want 0/0", trig, auto_fired);
    end
  endtask
`endif

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    adc_data     = '0;
    sample_valid = 1'b0;
    trig_reset   = 1'b0;
    cfg(8'd0, 8'd0, 1'b0, 16'd0, 16'd0);
    test_reset();
    test_rising();
    test_hyst_reject();
    test_fall_sat();
    test_arm_no_fire();
    test_holdoff();
    test_priority();
    test_async_reset();
    test_auto();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
